ptp_bridge_tcam_rsp: RTL and testbench
======================================

PTP_BRIDGE_TCAM_RSP -- requirements
Module: ptp_bridge_tcam_rsp

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default ptp_bridge_pkg::tuple_map_width, the lookup key width.
REQ-002 SHALL have parameter RESULT_WIDTH, default ptp_bridge_pkg::TCAM_RESULT_WIDTH, the result width.
REQ-003 SHALL have parameter ENTRIES, default 16, the table depth (2..64).
REQ-004 SHALL have parameters USERMETADATA_WIDTH, default 1, and CHTID_WIDTH, default 1, the passthrough widths.
REQ-005 SHALL use one clock and an asynchronous active-low reset, with these ports:
- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- tcam_req_tvalid  in  1  request valid
- tcam_req_tid  in  CHTID_WIDTH  request id
- tcam_req_tuser_key  in  KEY_WIDTH  lookup key
- tcam_req_tuser_usermetadata  in  USERMETADATA_WIDTH  echoed metadata
- tcam_req_tready  out  1  request accept
- tcam_rsp_tvalid  out  1  response valid
- tcam_rsp_tid  out  CHTID_WIDTH  echoed id
- tcam_rsp_tuser_result  out  RESULT_WIDTH  matched result
- tcam_rsp_tuser_found  out  1  hit flag
- tcam_rsp_tuser_usermetadata  out  USERMETADATA_WIDTH  echoed metadata
- tcam_rsp_tready  in  1  downstream accept
- cfg_wr_en  in  1  entry write strobe
- cfg_wr_idx  in  $clog2(ENTRIES)  entry index
- cfg_wr_vld  in  1  entry valid bit to write
- cfg_wr_key  in  KEY_WIDTH  entry key
- cfg_wr_mask  in  KEY_WIDTH  care mask, 1 = compare this bit
- cfg_wr_result  in  RESULT_WIDTH  entry result
- cfg_clr  in  1  invalidate all entries
- hit_cnt  out  32  saturating hit count
- miss_cnt  out  32  saturating miss count

Function
REQ-006 SHALL implement a two-stage pipeline: S1 is the capture register and S2 is the output register driving tcam_rsp_*.
REQ-007 SHALL drive tcam_req_tready = ~s1_vld | ~s2_vld | tcam_rsp_tready, as a combinational function of registered state and tcam_rsp_tready only, with no dependence on tcam_req_tvalid.
REQ-008 SHALL capture tid, key and usermetadata into S1 on tcam_req_tvalid & tcam_req_tready.
REQ-009 SHALL move S1 into S2 when s1_vld & (~s2_vld | tcam_rsp_tready), and SHALL compute the match at that transfer.
REQ-010 SHALL deem entry i matching iff vld[i] & (((key ^ ekey[i]) & emask[i]) == 0); all-zero mask matches any key.
REQ-011 SHALL select the lowest-index matching entry, setting found=1 and result=eresult[idx].
REQ-012 SHALL set found=0 and result='0 when no entry matches.
REQ-013 SHALL give latency of exactly 2 cycles from request accept to tcam_rsp_tvalid with no backpressure, at a sustained throughput of 1 per cycle.
REQ-014 SHALL hold all tcam_rsp_* outputs stable while tcam_rsp_tvalid & ~tcam_rsp_tready.
REQ-015 SHALL return responses in request order, with no drop and no duplication.
REQ-016 SHALL, when the pipeline is full and tcam_rsp_tready=0, deassert tcam_req_tready in the same cycle and accept nothing.
REQ-017 SHALL make cfg_wr_en write vld/key/mask/result at cfg_wr_idx at the clock edge; an S1->S2 match in that same cycle uses the pre-write table.
REQ-018 SHALL make cfg_clr clear all vld bits at the edge; cfg_clr takes priority over a simultaneous cfg_wr_en.
REQ-019 SHALL ignore cfg_wr_en when cfg_wr_idx >= ENTRIES.
REQ-020 SHALL increment hit_cnt or miss_cnt once per response handshake (tcam_rsp_tvalid & tcam_rsp_tready) according to found, saturating at 32'hFFFFFFFF.

Reset
REQ-021 SHALL, while rst_n=0, asynchronously clear s1_vld, s2_vld, all entry vld bits, hit_cnt and miss_cnt.
REQ-022 SHALL drive tcam_rsp_tvalid=0, found=0, result='0 and tcam_req_tready=1 during reset and on the first cycle after release.
REQ-023 SHALL need no reset on data, key, mask or result storage.
REQ-024 SHALL discard any in-flight request on reset assertion mid-operation, with no response emitted after release.

Verification
REQ-025 SHALL pass this scenario: write idx3 key=K mask=all-ones result=0x5, then request key=K, tid=1, rsp_tready=1 -> 2 cycles later rsp_tvalid=1, found=1, result=0x5, tid=1, hit_cnt=1.
REQ-026 SHALL pass this scenario: idx2 and idx5 both match key K with results 0xA and 0xB -> result=0xA; after idx2 is written with vld=0 -> result=0xB.
REQ-027 SHALL pass this scenario: request with an empty table -> found=0, result=0, miss_cnt=1; after cfg_clr, the previously hitting key misses.
REQ-028 SHALL pass this scenario: 4 back-to-back requests with rsp_tready held 0 -> 2 accepted, then tcam_req_tready=0 and outputs stable; rsp_tready=1 -> all 4 responses in order, no gaps after unstall.
REQ-029 SHALL pass this scenario: cfg_wr_en and an S1->S2 transfer in the same cycle on the matched entry -> old result returned; the next request returns the new result.
REQ-030 SHALL pass this scenario: rst_n pulsed low while both stages are valid -> tcam_rsp_tvalid=0 immediately, counters=0, all keys miss after release.

Source files
------------

// File: rtl/ptp_bridge_tcam_rsp.sv
// Ternary lookup table with registered request capture and response stages.
// Latency: 2 cycles from request accept to tcam_rsp_tvalid, 1 lookup per cycle sustained.
// Backpressure: req_tready drops only when both stages hold data and rsp_tready=0.

package ptp_bridge_pkg;
  localparam int tuple_map_width   = 16;
  localparam int TCAM_RESULT_WIDTH = 8;
endpackage

module ptp_bridge_tcam_rsp #(
  parameter int KEY_WIDTH          = ptp_bridge_pkg::tuple_map_width,
  parameter int RESULT_WIDTH       = ptp_bridge_pkg::TCAM_RESULT_WIDTH,
  parameter int ENTRIES            = 16,
  parameter int USERMETADATA_WIDTH = 1,
  parameter int CHTID_WIDTH        = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tcam_req_tvalid,
  input  logic [CHTID_WIDTH-1:0]        tcam_req_tid,
  input  logic [KEY_WIDTH-1:0]          tcam_req_tuser_key,
  input  logic [USERMETADATA_WIDTH-1:0] tcam_req_tuser_usermetadata,
  output logic                          tcam_req_tready,
  output logic                          tcam_rsp_tvalid,
  output logic [CHTID_WIDTH-1:0]        tcam_rsp_tid,
  output logic [RESULT_WIDTH-1:0]       tcam_rsp_tuser_result,
  output logic                          tcam_rsp_tuser_found,
  output logic [USERMETADATA_WIDTH-1:0] tcam_rsp_tuser_usermetadata,
  input  logic                          tcam_rsp_tready,
  input  logic                          cfg_wr_en,
  input  logic [$clog2(ENTRIES)-1:0]    cfg_wr_idx,
  input  logic                          cfg_wr_vld,
  input  logic [KEY_WIDTH-1:0]          cfg_wr_key,
  input  logic [KEY_WIDTH-1:0]          cfg_wr_mask,
  input  logic [RESULT_WIDTH-1:0]       cfg_wr_result,
  input  logic                          cfg_clr,
  output logic [31:0]                   hit_cnt,
  output logic [31:0]                   miss_cnt
);

  typedef struct packed {
    logic [CHTID_WIDTH-1:0]        tid;
    logic [KEY_WIDTH-1:0]          key;
    logic [USERMETADATA_WIDTH-1:0] meta;
  } s1_dat_t;

  typedef struct packed {
    logic [CHTID_WIDTH-1:0]        tid;
    logic                          found;
    logic [RESULT_WIDTH-1:0]       result;
    logic [USERMETADATA_WIDTH-1:0] meta;
  } s2_dat_t;

  logic                    s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  s1_dat_t                 s1_dat_q, s1_dat_d;
  s2_dat_t                 s2_dat_q, s2_dat_d;
  logic [ENTRIES-1:0]      tbl_vld_q, tbl_vld_d;
  logic [KEY_WIDTH-1:0]    tbl_key_q  [ENTRIES];
  logic [KEY_WIDTH-1:0]    tbl_key_d  [ENTRIES];
  logic [KEY_WIDTH-1:0]    tbl_mask_q [ENTRIES];
  logic [KEY_WIDTH-1:0]    tbl_mask_d [ENTRIES];
  logic [RESULT_WIDTH-1:0] tbl_res_q  [ENTRIES];
  logic [RESULT_WIDTH-1:0] tbl_res_d  [ENTRIES];
  logic [31:0]             hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic                    req_acc, s1_adv, rsp_hs, cfg_wr_ok;
  logic                    lkp_found;
  logic [RESULT_WIDTH-1:0] lkp_result;

  // Ready depends only on stage occupancy and downstream ready, never on req_tvalid.
  assign tcam_req_tready = ~s1_vld_q | ~s2_vld_q | tcam_rsp_tready;
  assign req_acc         = tcam_req_tvalid & tcam_req_tready;
  assign s1_adv          = s1_vld_q & (~s2_vld_q | tcam_rsp_tready);
  assign rsp_hs          = s2_vld_q & tcam_rsp_tready;
  assign cfg_wr_ok       = cfg_wr_en & (32'(cfg_wr_idx) < ENTRIES);

  // Priority match on the S1 key against the current (pre-write) table; lowest index wins.
  always_comb begin
    lkp_found  = 1'b0;
    lkp_result = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (tbl_vld_q[i] && (((s1_dat_q.key ^ tbl_key_q[i]) & tbl_mask_q[i]) == '0)) begin
        lkp_found  = 1'b1;
        lkp_result = tbl_res_q[i];
      end
    end
  end

  // Pipeline next state: S1 capture on accept, S2 load on advance, S2 holds while stalled.
  always_comb begin
    s1_vld_d = req_acc | (s1_vld_q & ~s1_adv);
    s1_dat_d = s1_dat_q;
    if (req_acc) begin
      s1_dat_d = '{tid: tcam_req_tid, key: tcam_req_tuser_key, meta: tcam_req_tuser_usermetadata};
    end
    s2_vld_d = s1_adv | (s2_vld_q & ~tcam_rsp_tready);
    s2_dat_d = s2_dat_q;
    if (s1_adv) begin
      s2_dat_d = '{tid: s1_dat_q.tid, found: lkp_found, result: lkp_result, meta: s1_dat_q.meta};
    end
  end

  // Table update: clear-all beats a simultaneous entry write; out-of-range index is dropped.
  always_comb begin
    tbl_vld_d  = tbl_vld_q;
    tbl_key_d  = tbl_key_q;
    tbl_mask_d = tbl_mask_q;
    tbl_res_d  = tbl_res_q;
    if (cfg_clr) begin
      tbl_vld_d = '0;
    end else if (cfg_wr_ok) begin
      tbl_vld_d[cfg_wr_idx]  = cfg_wr_vld;
      tbl_key_d[cfg_wr_idx]  = cfg_wr_key;
      tbl_mask_d[cfg_wr_idx] = cfg_wr_mask;
      tbl_res_d[cfg_wr_idx]  = cfg_wr_result;
    end
  end

  // Saturating hit/miss counters, one step per response handshake.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (rsp_hs) begin
      if (s2_dat_q.found) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  // Control state and response register; response data is cleared so found/result read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_dat_q   <= '0;
      tbl_vld_q  <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s2_vld_q   <= s2_vld_d;
      s2_dat_q   <= s2_dat_d;
      tbl_vld_q  <= tbl_vld_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Payload and table storage need no reset; their valid bits qualify them.
  always_ff @(posedge clk) begin
    s1_dat_q   <= s1_dat_d;
    tbl_key_q  <= tbl_key_d;
    tbl_mask_q <= tbl_mask_d;
    tbl_res_q  <= tbl_res_d;
  end

  assign tcam_rsp_tvalid             = s2_vld_q;
  assign tcam_rsp_tid                = s2_dat_q.tid;
  assign tcam_rsp_tuser_found        = s2_dat_q.found;
  assign tcam_rsp_tuser_result       = s2_dat_q.result;
  assign tcam_rsp_tuser_usermetadata = s2_dat_q.meta;
  assign hit_cnt                     = hit_cnt_q;
  assign miss_cnt                    = miss_cnt_q;

endmodule

// File: tb/tb_ptp_bridge_tcam_rsp.sv
// Bench for ptp_bridge_tcam_rsp: directed scenarios plus randomized traffic vs a table model.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Responses are recorded at each handshake and compared in order against expected responses.
module tb_ptp_bridge_tcam_rsp;
  localparam int KW = 16, RW = 8, ENT = 12, MW = 4, TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, tcam_req_tvalid, tcam_req_tready, tcam_rsp_tvalid, tcam_rsp_tuser_found, tcam_rsp_tready;
  logic [TW-1:0] tcam_req_tid, tcam_rsp_tid;
  logic [KW-1:0] tcam_req_tuser_key, cfg_wr_key, cfg_wr_mask;
  logic [MW-1:0] tcam_req_tuser_usermetadata, tcam_rsp_tuser_usermetadata;
  logic [RW-1:0] tcam_rsp_tuser_result, cfg_wr_result;
  logic cfg_wr_en, cfg_wr_vld, cfg_clr;
  logic [3:0] cfg_wr_idx;
  logic [31:0] hit_cnt, miss_cnt;

  ptp_bridge_tcam_rsp #(.KEY_WIDTH(KW), .RESULT_WIDTH(RW), .ENTRIES(ENT),
                        .USERMETADATA_WIDTH(MW), .CHTID_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .tcam_req_tvalid(tcam_req_tvalid), .tcam_req_tid(tcam_req_tid),
    .tcam_req_tuser_key(tcam_req_tuser_key), .tcam_req_tuser_usermetadata(tcam_req_tuser_usermetadata),
    .tcam_req_tready(tcam_req_tready), .tcam_rsp_tvalid(tcam_rsp_tvalid), .tcam_rsp_tid(tcam_rsp_tid),
    .tcam_rsp_tuser_result(tcam_rsp_tuser_result), .tcam_rsp_tuser_found(tcam_rsp_tuser_found),
    .tcam_rsp_tuser_usermetadata(tcam_rsp_tuser_usermetadata), .tcam_rsp_tready(tcam_rsp_tready),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_idx(cfg_wr_idx), .cfg_wr_vld(cfg_wr_vld), .cfg_wr_key(cfg_wr_key),
    .cfg_wr_mask(cfg_wr_mask), .cfg_wr_result(cfg_wr_result), .cfg_clr(cfg_clr),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

  typedef struct packed {
    logic [TW-1:0] tid;
    logic          found;
    logic [RW-1:0] result;
    logic [MW-1:0] meta;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t obs_q[$];
  int   obs_cyc[$];
  int   cyc = 0;
  int   checks = 0, failures = 0, accepted = 0, issue_to = 0;

  // Reference table: the response to a key is the first valid entry whose cared bits agree.
  logic          m_vld [16];
  logic [KW-1:0] m_key [16];
  logic [KW-1:0] m_mask[16];
  logic [RW-1:0] m_res [16];
  int unsigned   m_hits, m_miss;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (rst_n && tcam_rsp_tvalid && tcam_rsp_tready) begin
      obs_q.push_back({tcam_rsp_tid, tcam_rsp_tuser_found, tcam_rsp_tuser_result, tcam_rsp_tuser_usermetadata});
      obs_cyc.push_back(cyc);
    end

  function automatic rsp_t model_rsp(input logic [TW-1:0] tid, input logic [KW-1:0] key, input logic [MW-1:0] meta);
    rsp_t r;
    r = '0;
    r.tid  = tid;
    r.meta = meta;
    for (int i = 0; i < ENT; i++)
      if (m_vld[i] && (((key ^ m_key[i]) & m_mask[i]) == '0)) begin
        r.found  = 1'b1;
        r.result = m_res[i];
        break;
      end
    return r;
  endfunction

  task automatic clear_q();
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tcam_req_tvalid = 1'b0; cfg_wr_en = 1'b0; cfg_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_clear(); m_hits = 0; m_miss = 0; clear_q();
    rst_n = 1'b1;
  endtask

  task automatic cfg_write(input int idx, input logic vld, input logic [KW-1:0] key,
                           input logic [KW-1:0] mask, input logic [RW-1:0] res);
    cfg_wr_en = 1'b1; cfg_wr_idx = 4'(idx); cfg_wr_vld = vld;
    cfg_wr_key = key; cfg_wr_mask = mask; cfg_wr_result = res;
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
    if (idx < ENT) begin
      m_vld[idx] = vld; m_key[idx] = key; m_mask[idx] = mask; m_res[idx] = res;
    end
  endtask

  task automatic cfg_clear();
    cfg_clr = 1'b1;
    @(posedge clk); #1;
    cfg_clr = 1'b0;
    model_clear();
  endtask

  task automatic issue(input logic [TW-1:0] tid, input logic [KW-1:0] key, input logic [MW-1:0] meta);
    rsp_t r;
    logic rdy;
    bit   ok = 0;
    tcam_req_tvalid = 1'b1; tcam_req_tid = tid; tcam_req_tuser_key = key; tcam_req_tuser_usermetadata = meta;
    r = model_rsp(tid, key, meta);
    for (int c = 0; c < 500; c++) begin
      @(negedge clk); rdy = tcam_req_tready;
      @(posedge clk); #1;
      if (rdy) begin ok = 1; break; end
    end
    tcam_req_tvalid = 1'b0;
    if (ok) begin
      accepted++;
      exp_q.push_back(r);
      if (r.found) m_hits++; else m_miss++;
    end else issue_to++;
  endtask

  task automatic wait_rsp(input int n, output bit ok);
    ok = 0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (obs_q.size() >= n) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tcam_rsp_tready = 1'b0; tcam_req_tvalid = 1'b0; cfg_wr_en = 1'b0; cfg_clr = 1'b0;
    tcam_req_tid = '0; tcam_req_tuser_key = '0; tcam_req_tuser_usermetadata = '0;
    cfg_wr_idx = '0; cfg_wr_vld = 1'b0; cfg_wr_key = '0; cfg_wr_mask = '0; cfg_wr_result = '0;
    #3;
    checks++; if ({tcam_rsp_tvalid, tcam_rsp_tuser_found, tcam_rsp_tuser_result} !== '0) begin failures++;
      $display("FAIL rst_outputs got=%h exp=0", {tcam_rsp_tvalid, tcam_rsp_tuser_found, tcam_rsp_tuser_result}); end
    checks++; if (tcam_req_tready !== 1'b1) begin failures++; $display("FAIL rst_req_tready got=%b exp=1", tcam_req_tready); end
    checks++; if ({hit_cnt, miss_cnt} !== 64'd0) begin failures++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
    do_reset();
    @(negedge clk);
    checks++; if ({tcam_rsp_tvalid, tcam_rsp_tuser_found, tcam_rsp_tuser_result, tcam_req_tready} !== {10'd0, 1'b1}) begin failures++;
      $display("FAIL post_rst_outputs got=%b%b%h%b exp=0 0 00 1", tcam_rsp_tvalid, tcam_rsp_tuser_found, tcam_rsp_tuser_result, tcam_req_tready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_hit();
    bit ok;
    clear_q(); tcam_rsp_tready = 1'b1;
    cfg_write(3, 1'b1, 16'h1234, 16'hFFFF, 8'h05);
    issue(4'd1, 16'h1234, 4'd9);
    @(negedge clk);
    checks++; if (tcam_rsp_tvalid !== 1'b0) begin failures++; $display("FAIL lat_early got=%b exp=0", tcam_rsp_tvalid); end
    @(posedge clk); #1; @(negedge clk);
    checks++; if ({tcam_rsp_tvalid, tcam_rsp_tuser_found, tcam_rsp_tuser_result, tcam_rsp_tid} !== {1'b1, 1'b1, 8'h05, 4'd1}) begin failures++;
      $display("FAIL basic_hit got=v%b f%b r%h t%h exp=v1 f1 r05 t1", tcam_rsp_tvalid, tcam_rsp_tuser_found, tcam_rsp_tuser_result, tcam_rsp_tid); end
    wait_rsp(1, ok);
    checks++; if (!ok || obs_q[0] !== exp_q[0]) begin failures++; $display("FAIL basic_model got=%h exp=%h", obs_q[0], exp_q[0]); end
    checks++; if (hit_cnt !== 32'd1 || miss_cnt !== 32'd0) begin failures++; $display("FAIL basic_cnt got=%0d/%0d exp=1/0", hit_cnt, miss_cnt); end
  endtask

  task automatic test_priority();
    bit ok;
    clear_q(); cfg_clear();
    cfg_write(2, 1'b1, 16'h0F0F, 16'hFFFF, 8'h0A);
    cfg_write(5, 1'b1, 16'h0F0F, 16'hFFFF, 8'h0B);
    issue(4'd2, 16'h0F0F, 4'd1);
    wait_rsp(1, ok);
    checks++; if (!ok || obs_q[0].result !== 8'h0A || obs_q[0] !== exp_q[0]) begin failures++; $display("FAIL prio_low got=%h exp=%h", obs_q[0], exp_q[0]); end
    cfg_write(2, 1'b0, 16'h0F0F, 16'hFFFF, 8'h0A);
    issue(4'd3, 16'h0F0F, 4'd2);
    wait_rsp(2, ok);
    checks++; if (!ok || obs_q[1].result !== 8'h0B || obs_q[1] !== exp_q[1]) begin failures++; $display("FAIL prio_next got=%h exp=%h", obs_q[1], exp_q[1]); end
  endtask

  task automatic test_miss_clr();
    bit ok;
    do_reset(); tcam_rsp_tready = 1'b1;
    issue(4'd4, 16'hBEEF, 4'd3);
    wait_rsp(1, ok);
    checks++; if (!ok || obs_q[0].found !== 1'b0 || obs_q[0].result !== 8'h00) begin failures++; $display("FAIL empty_miss got=%h exp found=0 result=0", obs_q[0]); end
    checks++; if (miss_cnt !== 32'd1) begin failures++; $display("FAIL empty_miss_cnt got=%0d exp=1", miss_cnt); end
    cfg_write(0, 1'b1, 16'hBEEF, 16'hFFFF, 8'h07);
    issue(4'd5, 16'hBEEF, 4'd4);
    cfg_clear();
    issue(4'd6, 16'hBEEF, 4'd5);
    wait_rsp(3, ok);
    checks++; if (!ok || obs_q[1].found !== 1'b1 || obs_q[2].found !== 1'b0 || obs_q[2] !== exp_q[2]) begin failures++;
      $display("FAIL clr_miss got=%h,%h exp=%h,%h", obs_q[1], obs_q[2], exp_q[1], exp_q[2]); end
    checks++; if (hit_cnt !== 32'd1 || miss_cnt !== 32'd2) begin failures++; $display("FAIL clr_cnt got=%0d/%0d exp=1/2", hit_cnt, miss_cnt); end
  endtask

  task automatic test_cfg_edges();
    bit ok;
    clear_q();
    cfg_write(13, 1'b1, 16'h0042, 16'hFFFF, 8'h33);
    cfg_wr_en = 1'b1; cfg_clr = 1'b1; cfg_wr_idx = 4'd4; cfg_wr_vld = 1'b1;
    cfg_wr_key = 16'h0077; cfg_wr_mask = 16'hFFFF; cfg_wr_result = 8'h44;
    @(posedge clk); #1;
    cfg_wr_en = 1'b0; cfg_clr = 1'b0; model_clear();
    issue(4'd7, 16'h0042, 4'd6);
    issue(4'd8, 16'h0077, 4'd7);
    wait_rsp(2, ok);
    checks++; if (!ok || obs_q[0].found !== 1'b0) begin failures++; $display("FAIL idx_range got=%h exp found=0", obs_q[0]); end
    checks++; if (!ok || obs_q[1].found !== 1'b0) begin failures++; $display("FAIL clr_priority got=%h exp found=0", obs_q[1]); end
    cfg_write(6, 1'b1, 16'h0000, 16'h0000, 8'h66);
    issue(4'd9, 16'hDEAD, 4'd8);
    wait_rsp(3, ok);
    checks++; if (!ok || obs_q[2].found !== 1'b1 || obs_q[2].result !== 8'h66) begin failures++; $display("FAIL zero_mask got=%h exp found=1 result=66", obs_q[2]); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [TW+RW+MW+1:0] snap;
    clear_q(); cfg_clear();
    cfg_write(1, 1'b1, 16'h0001, 16'h000F, 8'hC1);
    tcam_rsp_tready = 1'b0; accepted = 0;
    fork
      for (int i = 0; i < 4; i++) issue(4'(i + 10), 16'(i), 4'(i));
      begin
        repeat (6) @(posedge clk);
        #1;
        checks++; if (accepted != 2) begin failures++; $display("FAIL bp_accepted got=%0d exp=2", accepted); end
        checks++; if (tcam_req_tready !== 1'b0) begin failures++; $display("FAIL bp_req_tready got=%b exp=0", tcam_req_tready); end
        snap = {tcam_rsp_tvalid, tcam_rsp_tid, tcam_rsp_tuser_found, tcam_rsp_tuser_result, tcam_rsp_tuser_usermetadata};
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checks++; if ({tcam_rsp_tvalid, tcam_rsp_tid, tcam_rsp_tuser_found, tcam_rsp_tuser_result, tcam_rsp_tuser_usermetadata} !== snap || snap[TW+RW+MW+1] !== 1'b1) begin
            failures++; $display("FAIL bp_stable got=%h exp=%h", {tcam_rsp_tvalid, tcam_rsp_tid, tcam_rsp_tuser_found, tcam_rsp_tuser_result, tcam_rsp_tuser_usermetadata}, snap); end
        end
        @(posedge clk); #1;
        tcam_rsp_tready = 1'b1;
      end
    join
    wait_rsp(4, ok);
    for (int i = 0; i < 4; i++) begin
      checks++; if (!ok || obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (!ok || obs_cyc[i+1] != obs_cyc[i] + 1) begin failures++; $display("FAIL bp_gap[%0d] got=%0d exp=1", i, obs_cyc[i+1] - obs_cyc[i]); end
    end
  endtask

  task automatic test_cfg_collision();
    bit ok;
    clear_q(); cfg_clear();
    cfg_write(1, 1'b1, 16'h0055, 16'hFFFF, 8'h11);
    issue(4'd1, 16'h0055, 4'd1);
    cfg_wr_en = 1'b1; cfg_wr_idx = 4'd1; cfg_wr_vld = 1'b1; cfg_wr_key = 16'h0055; cfg_wr_mask = 16'hFFFF; cfg_wr_result = 8'h22;
    @(posedge clk); #1;
    cfg_wr_en = 1'b0; m_res[1] = 8'h22;
    issue(4'd2, 16'h0055, 4'd2);
    wait_rsp(2, ok);
    checks++; if (!ok || obs_q[0].result !== 8'h11 || obs_q[0] !== exp_q[0]) begin failures++; $display("FAIL coll_old got=%h exp=%h", obs_q[0], exp_q[0]); end
    checks++; if (!ok || obs_q[1].result !== 8'h22 || obs_q[1] !== exp_q[1]) begin failures++; $display("FAIL coll_new got=%h exp=%h", obs_q[1], exp_q[1]); end
  endtask

  task automatic test_random();
    bit ok;
    bit gen_done = 0;
    int bad = 0;
    clear_q(); cfg_clear(); issue_to = 0;
    for (int i = 0; i < 8; i++)
      cfg_write($urandom_range(0, ENT - 1), 1'($urandom_range(0, 3) != 0), 16'($urandom_range(0, 15)),
                16'($urandom), 8'($urandom));
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
          issue(4'($urandom), 16'($urandom_range(0, 15)), 4'($urandom));
        end
        gen_done = 1;
      end
      begin
        for (int c = 0; c < 3000 && !gen_done; c++) begin
          @(posedge clk); #1;
          tcam_rsp_tready = 1'($urandom_range(0, 1));
        end
        tcam_rsp_tready = 1'b1;
      end
    join
    wait_rsp(60, ok);
    checks++; if (issue_to != 0) begin failures++; $display("FAIL rnd_accept_timeout got=%0d exp=0", issue_to); end
    checks++; if (!ok || obs_q.size() != 60) begin failures++; $display("FAIL rnd_count got=%0d exp=60", obs_q.size()); end
    for (int i = 0; i < 60 && i < obs_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        if (bad < 5) $display("FAIL rnd_rsp[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    checks++; if (bad != 0) failures++;
    checks++; if (hit_cnt !== m_hits || miss_cnt !== m_miss) begin failures++; $display("FAIL rnd_cnt got=%0d/%0d exp=%0d/%0d", hit_cnt, miss_cnt, m_hits, m_miss); end
  endtask

  task automatic test_reset_midflight();
    bit ok;
    clear_q(); cfg_clear();
    cfg_write(0, 1'b1, 16'h00AA, 16'hFFFF, 8'h03);
    tcam_rsp_tready = 1'b0;
    issue(4'd1, 16'h00AA, 4'd1);
    issue(4'd2, 16'h00AA, 4'd2);
    rst_n = 1'b0;
    #1;
    checks++; if (tcam_rsp_tvalid !== 1'b0 || tcam_req_tready !== 1'b1) begin failures++; $display("FAIL mid_rst_valid got=%b/%b exp=0/1", tcam_rsp_tvalid, tcam_req_tready); end
    checks++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin failures++; $display("FAIL mid_rst_cnt got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
    repeat (2) @(posedge clk);
    #1;
    model_clear(); m_hits = 0; m_miss = 0; clear_q();
    rst_n = 1'b1; tcam_rsp_tready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL mid_rst_ghost got=%0d exp=0", obs_q.size()); end
    issue(4'd3, 16'h00AA, 4'd3);
    wait_rsp(1, ok);
    checks++; if (!ok || obs_q[0].found !== 1'b0 || obs_q[0] !== exp_q[0]) begin failures++; $display("FAIL mid_rst_miss got=%h exp=%h", obs_q[0], exp_q[0]); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_hit();
    test_priority();
    test_miss_clr();
    test_cfg_edges();
    test_backpressure();
    test_cfg_collision();
    test_random();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
